// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate L1 data cache.
// Ports: dc_* request/ack interface from the memory-access stage; mem_* req/gnt +
//   rvalid burst interface to backing memory (8-beat line reads, single-doubleword writes).
// Latency: load hit acks 1 cycle after capture; misses and stores ack after the memory handshake.
module dcache_ctrl #(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dc_req,
  input  logic [57:0] dc_line_addr,
  input  logic [2:0]  dc_word_select,
  input  logic [2:0]  dc_byte_offset,
  input  logic        dc_read_write_n,
  input  logic [1:0]  load_type,
  input  logic [1:0]  store_type,
  input  logic [63:0] dc_data_to_cache,
  output logic        dc_ack,
  output logic [63:0] dc_data_from_cache,
  output logic        mem_req,
  output logic        mem_we,
  output logic [60:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata
);

  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, FILL_REQ, FILL, WR_REQ, RESP} state_t;

  state_t state_q, state_d;

  // Captured request fields; held for the whole transaction.
  logic [57:0] line_q,  line_d;
  logic [2:0]  word_q,  word_d;
  logic [2:0]  off_q,   off_d;
  logic        rw_q,    rw_d;
  logic [1:0]  ltype_q, ltype_d;
  logic [1:0]  stype_q, stype_d;
  logic [63:0] sdata_q, sdata_d;
  logic [2:0]  cnt_q,   cnt_d;
  logic [LINES-1:0] valid_q, valid_d;

  // Storage arrays: written through explicit enables computed below.
  logic [63:0]      data_q [LINES*8];
  logic [TAG_W-1:0] tag_q  [LINES];

  logic               data_we;
  logic [INDEX_W+2:0] data_waddr;
  logic [63:0]        data_wdata;
  logic               tag_we;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               hit;
  logic [63:0]        rd_dw;

  assign idx   = line_q[INDEX_W-1:0];
  assign tag   = line_q[INDEX_W+TAG_W-1:INDEX_W];
  assign hit   = valid_q[idx] && (tag_q[idx] == tag);
  assign rd_dw = data_q[{idx, word_q}];

  // Lane geometry. sh is the number of lanes to the right of the accessed
  // field (8 - aligned_offset - size); misaligned low offset bits are dropped.
  logic [1:0]  acc_type;
  logic [2:0]  sh;
  logic [7:0]  base_strb;
  logic [63:0] size_mask;
  logic [7:0]  lane_strb;
  logic [63:0] lane_wdata;
  logic [63:0] lane_mask;
  logic [63:0] load_dat;
  logic [63:0] merged_dw;

  always_comb begin
    acc_type = rw_q ? ltype_q : stype_q;
    sh        = 3'd0;
    base_strb = 8'hFF;
    size_mask = '1;
    case (acc_type)
      2'b00: begin
        sh        = 3'd7 - off_q;
        base_strb = 8'h01;
        size_mask = 64'h0000_0000_0000_00FF;
      end
      2'b01: begin
        sh        = 3'd6 - {off_q[2:1], 1'b0};
        base_strb = 8'h03;
        size_mask = 64'h0000_0000_0000_FFFF;
      end
      2'b10: begin
        sh        = 3'd4 - {off_q[2], 2'b00};
        base_strb = 8'h0F;
        size_mask = 64'h0000_0000_FFFF_FFFF;
      end
      default: begin
        sh        = 3'd0;
        base_strb = 8'hFF;
        size_mask = '1;
      end
    endcase
    lane_strb  = base_strb << sh;
    lane_wdata = (sdata_q & size_mask) << {sh, 3'b000};
    load_dat   = (rd_dw >> {sh, 3'b000}) & size_mask;
    // Strobe bit i covers bits [8i+7:8i] (bit 7 = big-endian byte 0).
    lane_mask  = '0;
    for (int i = 0; i < 8; i++) begin
      lane_mask[8*i +: 8] = {8{lane_strb[i]}};
    end
    merged_dw  = (rd_dw & ~lane_mask) | lane_wdata;
  end

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    word_d  = word_q;
    off_d   = off_q;
    rw_d    = rw_q;
    ltype_d = ltype_q;
    stype_d = stype_q;
    sdata_d = sdata_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;

    data_we    = 1'b0;
    data_waddr = {idx, word_q};
    data_wdata = merged_dw;
    tag_we     = 1'b0;

    dc_ack             = 1'b0;
    dc_data_from_cache = '0;
    mem_req            = 1'b0;
    mem_we             = 1'b0;
    mem_addr           = '0;
    mem_wdata          = '0;
    mem_wstrb          = '0;

    case (state_q)
      IDLE: begin
        if (dc_req) begin
          line_d  = dc_line_addr;
          word_d  = dc_word_select;
          off_d   = dc_byte_offset;
          rw_d    = dc_read_write_n;
          ltype_d = load_type;
          stype_d = store_type;
          sdata_d = dc_data_to_cache;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (rw_q) begin
          if (hit) begin
            dc_ack             = 1'b1;
            dc_data_from_cache = load_dat;
            state_d            = IDLE;
          end else begin
            state_d = FILL_REQ;
          end
        end else begin
          // Write-through: a hit updates the cached copy now, memory is
          // always written; a miss does not allocate.
          data_we = hit;
          state_d = WR_REQ;
        end
      end
      FILL_REQ: begin
        mem_req  = 1'b1;
        mem_addr = {line_q, 3'b000};
        if (mem_gnt) begin
          cnt_d        = 3'd0;
          // Line stays invalid until its last beat lands.
          valid_d[idx] = 1'b0;
          state_d      = FILL;
        end
      end
      FILL: begin
        if (mem_rvalid) begin
          data_we    = 1'b1;
          data_waddr = {idx, cnt_q};
          data_wdata = mem_rdata;
          cnt_d      = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            tag_we       = 1'b1;
            valid_d[idx] = 1'b1;
            state_d      = RESP;
          end
        end
      end
      WR_REQ: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {line_q, word_q};
        mem_wdata = lane_wdata;
        mem_wstrb = lane_strb;
        if (mem_gnt) begin
          state_d = RESP;
        end
      end
      RESP: begin
        dc_ack             = 1'b1;
        dc_data_from_cache = rw_q ? load_dat : 64'h0;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      line_q  <= '0;
      word_q  <= '0;
      off_q   <= '0;
      rw_q    <= 1'b0;
      ltype_q <= '0;
      stype_q <= '0;
      sdata_q <= '0;
      cnt_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      word_q  <= word_d;
      off_q   <= off_d;
      rw_q    <= rw_d;
      ltype_q <= ltype_d;
      stype_q <= stype_d;
      sdata_q <= sdata_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  // Arrays carry no reset; the valid bits alone decide what is live.
  always_ff @(posedge clk) begin
    if (data_we && !reset) begin
      data_q[data_waddr] <= data_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we && !reset) begin
      tag_q[idx] <= tag;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed table of cache transactions against a backing-memory agent.
// Ports: none (top-level bench driving every dcache_ctrl port).
// Multi-cycle corners (reset mid-fill, refill afterwards) are hand-written sequences.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        dc_req;
  logic [57:0] dc_line_addr;
  logic [2:0]  dc_word_select;
  logic [2:0]  dc_byte_offset;
  logic        dc_read_write_n;
  logic [1:0]  load_type;
  logic [1:0]  store_type;
  logic [63:0] dc_data_to_cache;
  logic        dc_ack;
  logic [63:0] dc_data_from_cache;
  logic        mem_req;
  logic        mem_we;
  logic [60:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;

  always #5 clk = ~clk;

  dcache_ctrl #(.INDEX_W(6), .TAG_W(8)) dut (
    .clk(clk), .reset(reset), .dc_req(dc_req), .dc_line_addr(dc_line_addr),
    .dc_word_select(dc_word_select), .dc_byte_offset(dc_byte_offset),
    .dc_read_write_n(dc_read_write_n), .load_type(load_type), .store_type(store_type),
    .dc_data_to_cache(dc_data_to_cache), .dc_ack(dc_ack),
    .dc_data_from_cache(dc_data_from_cache), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  // Backing memory model: sparse overrides on top of a fixed pattern.
  logic [63:0] mem_m [logic [60:0]];

  function automatic logic [63:0] pat(input logic [60:0] a);
    return {3'b101, a} ^ 64'hC3C3_5A5A_0F0F_9696;
  endfunction

  function automatic logic [63:0] mem_rd(input logic [60:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return pat(a);
  endfunction

  int          fill_cnt  = 0;
  int          write_cnt = 0;
  int          beats     = 0;
  bit          agent_busy = 0;
  logic [7:0]  last_strb = '0;
  logic [63:0] last_wdata = '0;
  int          ack_cnt   = 0;

  always @(negedge clk) if (dc_ack === 1'b1) ack_cnt++;

  // Memory agent: grants one cycle after seeing mem_req, then streams
  // 8 beats with a one-cycle bubble before beat 3. It keeps streaming even
  // if the cache is reset, which exercises stray-beat rejection.
  initial begin
    logic [60:0] a;
    logic        we;
    logic [63:0] wd, cur;
    logic [7:0]  ws;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1 && reset === 1'b0) begin
        agent_busy = 1;
        a = mem_addr; we = mem_we; wd = mem_wdata; ws = mem_wstrb;
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        if (we) begin
          write_cnt++;
          last_strb = ws; last_wdata = wd;
          cur = mem_rd(a);
          for (int i = 0; i < 8; i++) if (ws[i]) cur[8*i +: 8] = wd[8*i +: 8];
          mem_m[a] = cur;
        end else begin
          fill_cnt++;
          beats = 0;
          for (int k = 0; k < 8; k++) begin
            if (k == 3) begin
              mem_rvalid = 1'b0;
              @(negedge clk);
            end
            mem_rvalid = 1'b1;
            mem_rdata  = mem_rd({a[60:3], 3'(k)});
            beats      = k + 1;
            @(negedge clk);
          end
          mem_rvalid = 1'b0;
          mem_rdata  = '0;
        end
        agent_busy = 0;
      end
    end
  end

  typedef struct {
    logic [57:0] line;
    logic [2:0]  word;
    logic [2:0]  off;
    logic        rw;
    logic [1:0]  typ;
    logic [63:0] sdata;
    logic [63:0] exp_data;
    int          exp_fill;
    int          exp_wr;
    bit          exp_hit;
    logic [7:0]  exp_strb;
    logic [63:0] exp_wdata;
  } vec_t;

  function automatic vec_t ld(input logic [57:0] line, input logic [2:0] word,
                              input logic [2:0] off, input logic [1:0] typ,
                              input logic [63:0] exp, input int fill);
    vec_t v;
    v.line = line; v.word = word; v.off = off; v.rw = 1'b1; v.typ = typ;
    v.sdata = 64'hDEAD_BEEF_DEAD_BEEF; v.exp_data = exp; v.exp_fill = fill;
    v.exp_wr = 0; v.exp_hit = (fill == 0); v.exp_strb = '0; v.exp_wdata = '0;
    return v;
  endfunction

  function automatic vec_t st(input logic [57:0] line, input logic [2:0] word,
                              input logic [2:0] off, input logic [1:0] typ,
                              input logic [63:0] sdata, input logic [7:0] strb,
                              input logic [63:0] wdata);
    vec_t v;
    v.line = line; v.word = word; v.off = off; v.rw = 1'b0; v.typ = typ;
    v.sdata = sdata; v.exp_data = '0; v.exp_fill = 0; v.exp_wr = 1;
    v.exp_hit = 0; v.exp_strb = strb; v.exp_wdata = wdata;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    dc_req           = 1'b1;
    dc_line_addr     = v.line;
    dc_word_select   = v.word;
    dc_byte_offset   = v.off;
    dc_read_write_n  = v.rw;
    load_type        = v.rw ? v.typ : ~v.typ;
    store_type       = v.rw ? ~v.typ : v.typ;
    dc_data_to_cache = v.sdata;
  endtask

  // Entered just after a negedge; lat counts cycles from capture edge to ack.
  task automatic do_req(input vec_t v, output logic [63:0] d, output int lat, output bit to);
    d = '0; lat = 0; to = 1;
    drive(v);
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (dc_ack === 1'b1) begin
        d = dc_data_from_cache; lat = c; to = 0;
        break;
      end
    end
    dc_req = 1'b0;
  endtask

  vec_t vecs [19];

  initial begin
    logic [63:0] d;
    int lat, f0, w0, a0;
    bit to;
    string nm;
    vec_t rv;

    mem_m[{58'h5, 3'd2}] = 64'h0123_4567_89AB_CDEF;

    vecs[0]  = ld(58'h5, 3'd2, 3'd4, 2'b10, 64'h0000_0000_89AB_CDEF, 1);
    vecs[1]  = ld(58'h5, 3'd2, 3'd1, 2'b00, 64'h0000_0000_0000_0023, 0);
    vecs[2]  = st(58'h5, 3'd2, 3'd3, 2'b00, 64'h0000_0000_0000_00FF, 8'h10, 64'h0000_00FF_0000_0000);
    vecs[3]  = ld(58'h5, 3'd2, 3'd0, 2'b11, 64'h0123_45FF_89AB_CDEF, 0);
    vecs[4]  = st(58'h9, 3'd0, 3'd0, 2'b11, 64'h1111_2222_3333_4444, 8'hFF, 64'h1111_2222_3333_4444);
    vecs[5]  = ld(58'h9, 3'd0, 3'd0, 2'b11, 64'h1111_2222_3333_4444, 1);
    vecs[6]  = ld(58'h45, 3'd2, 3'd0, 2'b11, pat({58'h45, 3'd2}), 1);
    vecs[7]  = ld(58'h5, 3'd2, 3'd0, 2'b11, 64'h0123_45FF_89AB_CDEF, 1);
    vecs[8]  = ld(58'h5, 3'd2, 3'd2, 2'b01, 64'h0000_0000_0000_45FF, 0);
    vecs[9]  = ld(58'h5, 3'd2, 3'd3, 2'b01, 64'h0000_0000_0000_45FF, 0);
    vecs[10] = ld(58'h5, 3'd2, 3'd6, 2'b10, 64'h0000_0000_89AB_CDEF, 0);
    vecs[11] = st(58'h5, 3'd2, 3'd6, 2'b01, 64'h0000_0000_1234_BEEF, 8'h03, 64'h0000_0000_0000_BEEF);
    vecs[12] = ld(58'h5, 3'd2, 3'd0, 2'b11, 64'h0123_45FF_89AB_BEEF, 0);
    vecs[13] = st(58'h45, 3'd7, 3'd0, 2'b10, 64'h0000_0000_CAFE_F00D, 8'hF0, 64'hCAFE_F00D_0000_0000);
    vecs[14] = st(58'h5, 3'd2, 3'd5, 2'b11, 64'hA0A1_A2A3_A4A5_A6A7, 8'hFF, 64'hA0A1_A2A3_A4A5_A6A7);
    vecs[15] = ld(58'h5, 3'd2, 3'd0, 2'b11, 64'hA0A1_A2A3_A4A5_A6A7, 0);
    vecs[16] = ld(58'h5, 3'd2, 3'd7, 2'b00, 64'h0000_0000_0000_00A7, 0);
    vecs[17] = ld(58'h5, 3'd3, 3'd0, 2'b11, pat({58'h5, 3'd3}), 0);
    vecs[18] = ld(58'h4005, 3'd2, 3'd0, 2'b11, 64'hA0A1_A2A3_A4A5_A6A7, 0);

    reset = 1'b1; dc_req = 1'b0; dc_line_addr = '0; dc_word_select = '0;
    dc_byte_offset = '0; dc_read_write_n = 1'b1; load_type = '0; store_type = '0;
    dc_data_to_cache = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", {63'b0, dc_ack}, 64'h0);
    check("rst_data", dc_data_from_cache, 64'h0);
    check("rst_mem_req", {63'b0, mem_req}, 64'h0);
    check("rst_mem_bus", {mem_we, mem_addr} | {56'b0, mem_wstrb} | mem_wdata, 64'h0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 19; i++) begin
      f0 = fill_cnt; w0 = write_cnt; a0 = ack_cnt;
      do_req(vecs[i], d, lat, to);
      repeat (3) @(negedge clk);
      $sformat(nm, "v%0d", i);
      check({nm, "_timeout"}, {63'b0, to}, 64'h0);
      check({nm, "_data"}, d, vecs[i].exp_data);
      check({nm, "_fills"}, 64'(fill_cnt - f0), 64'(vecs[i].exp_fill));
      check({nm, "_writes"}, 64'(write_cnt - w0), 64'(vecs[i].exp_wr));
      check({nm, "_acks"}, 64'(ack_cnt - a0), 64'h1);
      if (vecs[i].exp_hit) check({nm, "_hit_lat"}, 64'(lat), 64'h1);
      if (!vecs[i].rw) begin
        check({nm, "_wstrb"}, {56'b0, last_strb}, {56'b0, vecs[i].exp_strb});
        check({nm, "_wdata"}, last_wdata, vecs[i].exp_wdata);
      end
      check({nm, "_idle_req"}, {63'b0, mem_req}, 64'h0);
    end

    // Reset after the 4th fill beat has been consumed.
    rv = ld(58'h7, 3'd1, 3'd0, 2'b11, pat({58'h7, 3'd1}), 1);
    a0 = ack_cnt; f0 = fill_cnt;
    drive(rv);
    to = 1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (fill_cnt != f0 && beats >= 5) begin to = 0; break; end
    end
    check("rst_mid_reach_beat4", {63'b0, to}, 64'h0);
    reset = 1'b1; dc_req = 1'b0;
    @(negedge clk);
    check("rst_mid_req_drop", {63'b0, mem_req}, 64'h0);
    check("rst_mid_no_ack", {63'b0, dc_ack}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    to = 1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!agent_busy) begin to = 0; break; end
    end
    check("rst_mid_agent_done", {63'b0, to}, 64'h0);
    repeat (2) @(negedge clk);
    check("rst_mid_acks", 64'(ack_cnt - a0), 64'h0);
    check("rst_mid_idle_req", {63'b0, mem_req}, 64'h0);

    f0 = fill_cnt; a0 = ack_cnt;
    do_req(rv, d, lat, to);
    repeat (3) @(negedge clk);
    check("refill_timeout", {63'b0, to}, 64'h0);
    check("refill_fills", 64'(fill_cnt - f0), 64'h1);
    check("refill_beats", 64'(beats), 64'h8);
    check("refill_data", d, rv.exp_data);
    check("refill_acks", 64'(ack_cnt - a0), 64'h1);

    // The refilled line now hits.
    rv = ld(58'h7, 3'd5, 3'd4, 2'b10, {32'b0, pat({58'h7, 3'd5})[31:0]}, 0);
    f0 = fill_cnt;
    do_req(rv, d, lat, to);
    repeat (2) @(negedge clk);
    check("refill_hit_data", d, rv.exp_data);
    check("refill_hit_lat", 64'(lat), 64'h1);
    check("refill_hit_fills", 64'(fill_cnt - f0), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
    $fatal(1);
  end

endmodule
